// File: rtl/mc_seq_ctrl.sv
// rtl/mc_seq_ctrl.sv - multi-cycle instruction sequencer with fetch/memory wait timeout
module mc_seq_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic [4:0]       rt,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             IRWr,
    output logic             PCWr,
    output logic             RFWr_en,
    output logic             DMWr_en,
    output logic             DMRe_en,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic             bus_err
);

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd7
    } state_t;

    localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] TO_V = WC_W'(TIMEOUT);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wcnt_q;
    logic              is_jmp, is_link, is_br, is_ld, is_st, is_alu, is_nop;
    logic              in_wait, wait_ready, timeout;
    logic              unused_rt;

    // REGIMM branches are all handled alike, so rt carries no information here
    assign unused_rt = ^rt;
    assign state     = state_q;

    always_comb begin
        is_jmp  = (op == OP_J) || (op == OP_JAL) ||
                  ((op == OP_SPECIAL) && ((funct == FN_JR) || (funct == FN_JALR)));
        is_link = (op == OP_JAL) || ((op == OP_SPECIAL) && (funct == FN_JALR));
        is_br   = (op == 6'b000001) || (op == 6'b000100) || (op == 6'b000101) ||
                  (op == 6'b000110) || (op == 6'b000111);
        is_ld   = (op == 6'b100000) || (op == 6'b100001) || (op == 6'b100011) ||
                  (op == 6'b100100) || (op == 6'b100101);
        is_st   = (op == 6'b101000) || (op == 6'b101001) || (op == 6'b101011);
        is_alu  = ((op == OP_SPECIAL) && !is_jmp) || (op[5:3] == 3'b001);
        is_nop  = !(is_jmp || is_br || is_ld || is_st || is_alu);
    end

    assign in_wait    = (state_q == FETCH) || (state_q == MEM);
    assign wait_ready = (state_q == FETCH) ? imem_ready : dmem_ready;
    // A ready arriving in the cycle the count hits the limit still completes normally
    assign timeout    = (TIMEOUT != 0) && in_wait && !wait_ready && (wcnt_q == TO_V);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= BOOT;
            wcnt_q  <= '0;
            instret <= '0;
            bus_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_wait && !wait_ready && !timeout)
                wcnt_q <= wcnt_q + 1'b1;
            else
                wcnt_q <= '0;
            if (PCWr)
                instret <= instret + 1'b1;
            if (timeout)
                bus_err <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:   state_d = FETCH;
            FETCH: begin
                if (imem_ready)
                    state_d = DECODE;
                else if (timeout)
                    state_d = HALT;
            end
            DECODE: state_d = (is_jmp || is_nop) ? FETCH : EXEC;
            EXEC: begin
                if (is_alu)
                    state_d = WB;
                else if (is_ld || is_st)
                    state_d = MEM;
                else
                    state_d = FETCH;
            end
            MEM: begin
                if (dmem_ready)
                    state_d = is_ld ? WB : FETCH;
                else if (timeout)
                    state_d = HALT;
            end
            WB:     state_d = FETCH;
            HALT:   state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        RFWr_en  = 1'b0;
        DMWr_en  = 1'b0;
        DMRe_en  = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                IRWr     = imem_ready;
            end
            DECODE: begin
                if (is_jmp) begin
                    PCWr    = 1'b1;
                    RFWr_en = is_link;
                end else if (is_nop) begin
                    PCWr = 1'b1;
                end
            end
            EXEC:   PCWr = is_br;
            MEM: begin
                dmem_req = 1'b1;
                DMRe_en  = is_ld;
                DMWr_en  = is_st;
                PCWr     = is_st && dmem_ready;
            end
            WB: begin
                RFWr_en = 1'b1;
                PCWr    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
